// File: rtl/sap_u_control_sequencer_if.sv
// Control-strobe bundle between the SAP-U sequencer and the datapath blocks.
// The master side is the sequencer; the slave side is the datapath or bench.
interface sap_u_control_sequencer_if #(
  parameter int STEP_W   = 3,
  parameter int OPCODE_W = 4
);
  logic                run;
  logic                step_mode;
  logic                step_pulse;
  logic [OPCODE_W-1:0] instr_opcode;
  logic                pc_bus_enable_n;
  logic                pc_increment;
  logic                pc_load_n;
  logic                ram_load_mar_reg_n;
  logic                ram_bus_enable_n;
  logic                ram_write_enable_n;
  logic                ir_load_n;
  logic                ir_bus_enable_n;
  logic                reg_a_load_n;
  logic                reg_a_bus_enable_n;
  logic                reg_b_load_n;
  logic                alu_enable_n;
  logic                alu_subtract;
  logic                out_load_n;
  logic                halted;
  logic [STEP_W-1:0]   t_state;

  modport master (
    input  run, step_mode, step_pulse, instr_opcode,
    output pc_bus_enable_n, pc_increment, pc_load_n, ram_load_mar_reg_n,
           ram_bus_enable_n, ram_write_enable_n, ir_load_n, ir_bus_enable_n,
           reg_a_load_n, reg_a_bus_enable_n, reg_b_load_n, alu_enable_n,
           alu_subtract, out_load_n, halted, t_state
  );

  modport slave (
    output run, step_mode, step_pulse, instr_opcode,
    input  pc_bus_enable_n, pc_increment, pc_load_n, ram_load_mar_reg_n,
           ram_bus_enable_n, ram_write_enable_n, ir_load_n, ir_bus_enable_n,
           reg_a_load_n, reg_a_bus_enable_n, reg_b_load_n, alu_enable_n,
           alu_subtract, out_load_n, halted, t_state
  );
endinterface

// File: rtl/sap_u_control_sequencer.sv
// SAP-U microcoded sequencer: T-state counter plus combinational strobe decode.
// Instructions run 3-5 T-states; HLT parks the machine until reset.
module sap_u_control_sequencer #(
  parameter int STEP_W   = 3,
  parameter int OPCODE_W = 4
) (
  input logic                        clk,
  input logic                        reset,
  sap_u_control_sequencer_if.master  cs
);

  typedef enum logic [STEP_W-1:0] {
    T0 = STEP_W'(0),
    T1 = STEP_W'(1),
    T2 = STEP_W'(2),
    T3 = STEP_W'(3),
    T4 = STEP_W'(4)
  } tstate_e;

  typedef struct packed {
    logic co, ce, j, mi, ro, ri, ii, io, ai, ao, bi, eo, su, oi;
  } ctrl_t;

  localparam logic [OPCODE_W-1:0] OP_LDA = OPCODE_W'(4'h1);
  localparam logic [OPCODE_W-1:0] OP_ADD = OPCODE_W'(4'h2);
  localparam logic [OPCODE_W-1:0] OP_SUB = OPCODE_W'(4'h3);
  localparam logic [OPCODE_W-1:0] OP_STA = OPCODE_W'(4'h4);
  localparam logic [OPCODE_W-1:0] OP_LDI = OPCODE_W'(4'h5);
  localparam logic [OPCODE_W-1:0] OP_JMP = OPCODE_W'(4'h6);
  localparam logic [OPCODE_W-1:0] OP_OUT = OPCODE_W'(4'hE);
  localparam logic [OPCODE_W-1:0] OP_HLT = OPCODE_W'(4'hF);

  tstate_e state_q, state_d;
  logic    halted_q, halted_d;
  ctrl_t   ctrl, ctrl_g;
  logic    advance, last, is_alu, is_mem;

  always_comb begin
    is_alu   = (cs.instr_opcode == OP_ADD) || (cs.instr_opcode == OP_SUB);
    is_mem   = is_alu || (cs.instr_opcode == OP_LDA) || (cs.instr_opcode == OP_STA);
    advance  = cs.run & ~halted_q & (~cs.step_mode | cs.step_pulse);
    ctrl     = '0;
    last     = 1'b1;
    state_d  = state_q;
    halted_d = halted_q;

    // T0/T1 never look at the opcode: the IR only becomes valid at T2.
    case (state_q)
      T0: begin
        ctrl.co = 1'b1; ctrl.mi = 1'b1; last = 1'b0;
      end
      T1: begin
        ctrl.ro = 1'b1; ctrl.ii = 1'b1; ctrl.ce = 1'b1; last = 1'b0;
      end
      T2: begin
        last = ~is_mem;
        case (cs.instr_opcode)
          OP_LDA, OP_ADD, OP_SUB, OP_STA: begin ctrl.io = 1'b1; ctrl.mi = 1'b1; end
          OP_LDI: begin ctrl.io = 1'b1; ctrl.ai = 1'b1; end
          OP_JMP: begin ctrl.io = 1'b1; ctrl.j  = 1'b1; end
          OP_OUT: begin ctrl.ao = 1'b1; ctrl.oi = 1'b1; end
          default: ;
        endcase
      end
      T3: begin
        last = ~is_alu;
        case (cs.instr_opcode)
          OP_LDA: begin ctrl.ro = 1'b1; ctrl.ai = 1'b1; end
          OP_ADD: begin ctrl.ro = 1'b1; ctrl.bi = 1'b1; end
          // Subtract is raised a cycle early so the ALU has settled before EO.
          OP_SUB: begin ctrl.ro = 1'b1; ctrl.bi = 1'b1; ctrl.su = 1'b1; end
          OP_STA: begin ctrl.ao = 1'b1; ctrl.ri = 1'b1; end
          default: ;
        endcase
      end
      T4: begin
        ctrl.eo = 1'b1; ctrl.ai = 1'b1;
        ctrl.su = (cs.instr_opcode == OP_SUB);
      end
      default: ;
    endcase

    if (advance) begin
      if (state_q == T2 && cs.instr_opcode == OP_HLT) begin
        halted_d = 1'b1;
        state_d  = T0;
      end else if (last) begin
        state_d  = T0;
      end else begin
        state_d  = tstate_e'(state_q + STEP_W'(1));
      end
    end

    ctrl_g = (~reset & cs.run & ~halted_q) ? ctrl : '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= T0;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      halted_q <= halted_d;
    end
  end

  assign cs.pc_bus_enable_n    = ~ctrl_g.co;
  assign cs.pc_increment       =  ctrl_g.ce;
  assign cs.pc_load_n          = ~ctrl_g.j;
  assign cs.ram_load_mar_reg_n = ~ctrl_g.mi;
  assign cs.ram_bus_enable_n   = ~ctrl_g.ro;
  assign cs.ram_write_enable_n = ~ctrl_g.ri;
  assign cs.ir_load_n          = ~ctrl_g.ii;
  assign cs.ir_bus_enable_n    = ~ctrl_g.io;
  assign cs.reg_a_load_n       = ~ctrl_g.ai;
  assign cs.reg_a_bus_enable_n = ~ctrl_g.ao;
  assign cs.reg_b_load_n       = ~ctrl_g.bi;
  assign cs.alu_enable_n       = ~ctrl_g.eo;
  assign cs.alu_subtract       =  ctrl_g.su;
  assign cs.out_load_n         = ~ctrl_g.oi;
  assign cs.halted             = halted_q;
  assign cs.t_state            = state_q;

endmodule

// File: tb/tb_sap_u_control_sequencer.sv
// Directed bench for the SAP-U sequencer: strobes are compared as a 14-bit word
// built from the idle pattern with the expected active strobes flipped.
module tb_sap_u_control_sequencer;

  logic clk;
  logic reset;
  int   vecs;
  int   errs;

  sap_u_control_sequencer_if #(.STEP_W(3), .OPCODE_W(4)) cif ();

  sap_u_control_sequencer #(.STEP_W(3), .OPCODE_W(4)) dut (
    .clk   (clk),
    .reset (reset),
    .cs    (cif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {CO,CE,J,MI,RO,RI,II,IO,AI,AO,BI,EO,SU,OI} at their inactive levels
  localparam logic [13:0] IDLE = 14'b1_0_1_1_1_1_1_1_1_1_1_1_0_1;
  localparam logic [13:0] CO = 14'h2000, CE = 14'h1000, J  = 14'h0800, MI = 14'h0400;
  localparam logic [13:0] RO = 14'h0200, RI = 14'h0100, II = 14'h0080, IO = 14'h0040;
  localparam logic [13:0] AI = 14'h0020, AO = 14'h0010, BI = 14'h0008, EO = 14'h0004;
  localparam logic [13:0] SU = 14'h0002, OI = 14'h0001;

  function automatic logic [13:0] obs();
    return {cif.pc_bus_enable_n, cif.pc_increment, cif.pc_load_n, cif.ram_load_mar_reg_n,
            cif.ram_bus_enable_n, cif.ram_write_enable_n, cif.ir_load_n, cif.ir_bus_enable_n,
            cif.reg_a_load_n, cif.reg_a_bus_enable_n, cif.reg_b_load_n, cif.alu_enable_n,
            cif.alu_subtract, cif.out_load_n};
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    cyc();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    cif.run = 1'b1; cif.step_mode = 1'b0; cif.step_pulse = 1'b0; cif.instr_opcode = 4'h2;
    reset = 1'b1;
    cyc(); cyc();
    #1;
    vecs++; if (obs() !== IDLE) begin errs++; $display("FAIL reset_ctrl got %b want %b", obs(), IDLE); end
    vecs++; if (cif.t_state !== 3'd0) begin errs++; $display("FAIL reset_tstate got %0d want 0", cif.t_state); end
    vecs++; if (cif.halted !== 1'b0) begin errs++; $display("FAIL reset_halted got %b want 0", cif.halted); end
    reset = 1'b0;
    #1;
    vecs++; if (obs() !== (IDLE ^ (CO | MI))) begin errs++; $display("FAIL release_t0 got %b want %b", obs(), IDLE ^ (CO | MI)); end
    vecs++; if (cif.t_state !== 3'd0) begin errs++; $display("FAIL release_tstate got %0d want 0", cif.t_state); end
  endtask

  task automatic test_alu();
    logic [13:0] ec [6];
    int          et [6];
    logic [13:0] su;
    logic [3:0]  op;
    for (int k = 0; k < 2; k++) begin
      op = (k == 1) ? 4'h3 : 4'h2;
      su = (k == 1) ? SU : 14'h0;
      ec = '{IDLE ^ (CO | MI), IDLE ^ (RO | II | CE), IDLE ^ (IO | MI),
             IDLE ^ (RO | BI | su), IDLE ^ (EO | AI | su), IDLE ^ (CO | MI)};
      et = '{0, 1, 2, 3, 4, 0};
      cif.run = 1'b1; cif.step_mode = 1'b0; cif.instr_opcode = 4'hF;
      pulse_reset();
      for (int i = 0; i < 6; i++) begin
        // HLT on the bus during fetch must be ignored
        cif.instr_opcode = (i >= 2 && i <= 4) ? op : 4'hF;
        #1;
        vecs++; if (cif.t_state !== 3'(et[i])) begin errs++; $display("FAIL alu op%h step%0d tstate got %0d want %0d", op, i, cif.t_state, et[i]); end
        vecs++; if (obs() !== ec[i]) begin errs++; $display("FAIL alu op%h step%0d ctrl got %b want %b", op, i, obs(), ec[i]); end
        cyc();
      end
    end
  endtask

  task automatic test_short_ops();
    logic [3:0]  ops [7];
    logic [13:0] t2  [7];
    ops = '{4'h4, 4'h5, 4'h6, 4'hE, 4'h0, 4'h9, 4'hD};
    t2  = '{IDLE ^ (IO | MI), IDLE ^ (IO | AI), IDLE ^ (IO | J), IDLE ^ (AO | OI),
            IDLE, IDLE, IDLE};
    for (int j = 0; j < 7; j++) begin
      cif.run = 1'b1; cif.step_mode = 1'b0; cif.instr_opcode = 4'hF;
      pulse_reset();
      cyc(); cyc();
      cif.instr_opcode = ops[j];
      #1;
      vecs++; if (cif.t_state !== 3'd2) begin errs++; $display("FAIL op%h t2 tstate got %0d want 2", ops[j], cif.t_state); end
      vecs++; if (obs() !== t2[j]) begin errs++; $display("FAIL op%h t2 ctrl got %b want %b", ops[j], obs(), t2[j]); end
      cyc();
      if (ops[j] == 4'h4) begin
        vecs++; if (obs() !== (IDLE ^ (AO | RI)) || cif.t_state !== 3'd3) begin
          errs++; $display("FAIL sta t3 ctrl got %b want %b tstate %0d", obs(), IDLE ^ (AO | RI), cif.t_state);
        end
        cyc();
      end
      vecs++; if (cif.t_state !== 3'd0) begin errs++; $display("FAIL op%h end tstate got %0d want 0", ops[j], cif.t_state); end
      vecs++; if (obs() !== (IDLE ^ (CO | MI))) begin errs++; $display("FAIL op%h next_t0 ctrl got %b want %b", ops[j], obs(), IDLE ^ (CO | MI)); end
    end
  endtask

  task automatic test_halt();
    cif.run = 1'b1; cif.step_mode = 1'b0; cif.instr_opcode = 4'hF;
    pulse_reset();
    cyc(); cyc();
    #1;
    vecs++; if (cif.t_state !== 3'd2 || obs() !== IDLE || cif.halted !== 1'b0) begin
      errs++; $display("FAIL hlt_t2 tstate %0d ctrl %b halted %b want 2 %b 0", cif.t_state, obs(), IDLE, cif.halted);
    end
    cyc();
    vecs++; if (cif.halted !== 1'b1) begin errs++; $display("FAIL hlt_flag got %b want 1", cif.halted); end
    for (int i = 0; i < 20; i++) begin
      cif.instr_opcode = 4'(i);
      #1;
      vecs++; if (obs() !== IDLE || cif.t_state !== 3'd0 || cif.halted !== 1'b1) begin
        errs++; $display("FAIL halted_hold cyc%0d ctrl %b tstate %0d halted %b want %b 0 1", i, obs(), cif.t_state, cif.halted, IDLE);
      end
      cyc();
    end
    cif.instr_opcode = 4'h2;
    pulse_reset();
    #1;
    vecs++; if (cif.halted !== 1'b0) begin errs++; $display("FAIL hlt_clear got %b want 0", cif.halted); end
    vecs++; if (obs() !== (IDLE ^ (CO | MI))) begin errs++; $display("FAIL hlt_refetch ctrl got %b want %b", obs(), IDLE ^ (CO | MI)); end
    cyc();
    vecs++; if (cif.t_state !== 3'd1 || obs() !== (IDLE ^ (RO | II | CE))) begin
      errs++; $display("FAIL hlt_t1 tstate %0d ctrl %b want 1 %b", cif.t_state, obs(), IDLE ^ (RO | II | CE));
    end
  endtask

  task automatic test_step_run();
    int exp_t;
    cif.run = 1'b1; cif.step_mode = 1'b1; cif.step_pulse = 1'b0; cif.instr_opcode = 4'hF;
    pulse_reset();
    exp_t = 0;
    for (int c = 0; c < 12; c++) begin
      cif.step_pulse   = (c % 4 == 3);
      cif.instr_opcode = (exp_t >= 2) ? 4'h1 : 4'hF;
      #1;
      vecs++; if (cif.t_state !== 3'(exp_t)) begin errs++; $display("FAIL step c%0d tstate got %0d want %0d", c, cif.t_state, exp_t); end
      cyc();
      if (c % 4 == 3) exp_t = (exp_t == 3) ? 0 : exp_t + 1;
    end
    cif.step_pulse = 1'b0; cif.instr_opcode = 4'h1;
    #1;
    vecs++; if (cif.t_state !== 3'd3 || obs() !== (IDLE ^ (RO | AI))) begin
      errs++; $display("FAIL step_t3 tstate %0d ctrl %b want 3 %b", cif.t_state, obs(), IDLE ^ (RO | AI));
    end
    cif.run = 1'b0; cif.step_pulse = 1'b1;
    #1;
    vecs++; if (obs() !== IDLE) begin errs++; $display("FAIL run0_ctrl got %b want %b", obs(), IDLE); end
    cyc(); cyc();
    vecs++; if (cif.t_state !== 3'd3) begin errs++; $display("FAIL run0_freeze tstate got %0d want 3", cif.t_state); end
    cif.run = 1'b1; cif.step_pulse = 1'b0;
    #1;
    vecs++; if (cif.t_state !== 3'd3 || obs() !== (IDLE ^ (RO | AI))) begin
      errs++; $display("FAIL run1_resume tstate %0d ctrl %b want 3 %b", cif.t_state, obs(), IDLE ^ (RO | AI));
    end
    cyc();
    vecs++; if (cif.t_state !== 3'd3) begin errs++; $display("FAIL step_nopulse tstate got %0d want 3", cif.t_state); end
    cif.step_pulse = 1'b1;
    cyc(); cyc(); cyc();
    cif.step_pulse = 1'b0;
    #1;
    vecs++; if (cif.t_state !== 3'd2) begin errs++; $display("FAIL step_held tstate got %0d want 2", cif.t_state); end
    cif.step_mode = 1'b0;
  endtask

  task automatic test_random();
    int instr, cycles, nlow;
    bit injected;
    cif.run = 1'b1; cif.step_mode = 1'b0; cif.step_pulse = 1'b0; cif.instr_opcode = 4'h0;
    pulse_reset();
    instr = 0; cycles = 0; injected = 1'b0;
    while (instr < 500 && cycles < 4000) begin
      if (cif.t_state == 3'd0) begin
        cif.instr_opcode = 4'($urandom_range(0, 14));
        instr++;
      end
      if (!injected && instr >= 250 && cif.t_state == 3'd3) begin
        reset = 1'b1;
        #1;
        vecs++; if (obs() !== IDLE) begin errs++; $display("FAIL inj_reset ctrl got %b want %b", obs(), IDLE); end
        cyc();
        reset = 1'b0;
        #1;
        vecs++; if (cif.t_state !== 3'd0 || cif.halted !== 1'b0) begin
          errs++; $display("FAIL inj_after tstate %0d halted %b want 0 0", cif.t_state, cif.halted);
        end
        injected = 1'b1;
      end
      #1;
      nlow = int'(!cif.pc_bus_enable_n) + int'(!cif.ram_bus_enable_n) + int'(!cif.ir_bus_enable_n)
           + int'(!cif.reg_a_bus_enable_n) + int'(!cif.alu_enable_n);
      vecs++; if (nlow > 1 || cif.t_state > 3'd4) begin
        errs++; $display("FAIL contention cyc%0d drivers %0d tstate %0d want <=1 <=4", cycles, nlow, cif.t_state);
      end
      cyc();
      cycles++;
    end
    vecs++; if (instr < 500) begin errs++; $display("FAIL random_budget instrs %0d want 500", instr); end
    vecs++; if (!injected) begin errs++; $display("FAIL random_inject got 0 want 1"); end
  endtask

  initial begin
    vecs = 0; errs = 0;
    reset = 1'b1;
    cif.run = 1'b0; cif.step_mode = 1'b0; cif.step_pulse = 1'b0; cif.instr_opcode = 4'h0;
    test_reset();
    test_alu();
    test_short_ops();
    test_halt();
    test_step_run();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog sim time %0t want completion", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
